// File: rtl/jtag_debug_cmd_scheduler.sv
// Clock-domain side of the JTAG debug command path: synchronizes the TCK toggle
// request, snapshots sr/ir, waits for the debug slave, and fires one action strobe.
module jtag_debug_cmd_scheduler #(
    parameter int SYNC_STAGES   = 2,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_tgl,
    input  logic [1:0]  ir_in,
    input  logic [37:0] sr,
    input  logic        avs_busy,
    input  logic        err_clr,
    output logic        ack_tgl,
    output logic [37:0] jdo,
    output logic        take_action_ocimem_a,
    output logic        take_action_ocimem_b,
    output logic        take_action_tracemem_a,
    output logic        take_action_tracemem_b,
    output logic        take_action_break_a,
    output logic        take_action_break_b,
    output logic        take_action_break_c,
    output logic        take_action_tracectrl,
    output logic        take_no_action_ocimem_a,
    output logic        take_no_action_tracemem_a,
    output logic        take_no_action_break_a,
    output logic        busy,
    output logic        overrun_err,
    output logic        timeout_err
);

    // state      | meaning
    // IDLE       | waiting for a request edge
    // CAPTURE    | latch sr into jdo and ir_in into ir_l
    // WAIT_GRANT | debug slave busy; count towards timeout
    // ISSUE      | register the decoded strobe
    // DONE       | toggle ack back to the TCK side

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CAPTURE    = 3'd1,
        WAIT_GRANT = 3'd2,
        ISSUE      = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(GRANT_TIMEOUT - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   edge_reg;
    logic                   req_edge;
    logic [1:0]             ir_l;
    logic [15:0]            cnt;

    assign req_edge = sync_ff[SYNC_STAGES-1] ^ edge_reg;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff  <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], req_tgl};
            edge_reg <= sync_ff[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                     <= IDLE;
            jdo                       <= '0;
            ir_l                      <= '0;
            cnt                       <= '0;
            ack_tgl                   <= 1'b0;
            overrun_err               <= 1'b0;
            timeout_err               <= 1'b0;
            take_action_ocimem_a      <= 1'b0;
            take_action_ocimem_b      <= 1'b0;
            take_action_tracemem_a    <= 1'b0;
            take_action_tracemem_b    <= 1'b0;
            take_action_break_a       <= 1'b0;
            take_action_break_b       <= 1'b0;
            take_action_break_c       <= 1'b0;
            take_action_tracectrl     <= 1'b0;
            take_no_action_ocimem_a   <= 1'b0;
            take_no_action_tracemem_a <= 1'b0;
            take_no_action_break_a    <= 1'b0;
        end else begin
            take_action_ocimem_a      <= 1'b0;
            take_action_ocimem_b      <= 1'b0;
            take_action_tracemem_a    <= 1'b0;
            take_action_tracemem_b    <= 1'b0;
            take_action_break_a       <= 1'b0;
            take_action_break_b       <= 1'b0;
            take_action_break_c       <= 1'b0;
            take_action_tracectrl     <= 1'b0;
            take_no_action_ocimem_a   <= 1'b0;
            take_no_action_tracemem_a <= 1'b0;
            take_no_action_break_a    <= 1'b0;

            // Clear first so a same-cycle set below takes priority.
            if (err_clr) begin
                overrun_err <= 1'b0;
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_edge) state <= CAPTURE;
                end
                CAPTURE: begin
                    jdo   <= sr;
                    ir_l  <= ir_in;
                    cnt   <= '0;
                    state <= avs_busy ? WAIT_GRANT : ISSUE;
                end
                WAIT_GRANT: begin
                    if (!avs_busy) begin
                        state <= ISSUE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ISSUE: begin
                    case (ir_l)
                        2'b00: begin
                            if (jdo[34])      take_action_ocimem_b    <= 1'b1;
                            else if (jdo[35]) take_action_ocimem_a    <= 1'b1;
                            else              take_no_action_ocimem_a <= 1'b1;
                        end
                        2'b01: begin
                            if (jdo[37])      take_action_tracemem_b    <= 1'b1;
                            else if (jdo[36]) take_action_tracemem_a    <= 1'b1;
                            else              take_no_action_tracemem_a <= 1'b1;
                        end
                        2'b10: begin
                            case (jdo[37:36])
                                2'b01:   take_action_break_a    <= 1'b1;
                                2'b10:   take_action_break_b    <= 1'b1;
                                2'b11:   take_action_break_c    <= 1'b1;
                                default: take_no_action_break_a <= 1'b1;
                            endcase
                        end
                        default: begin
                            if (jdo[15]) take_action_tracectrl <= 1'b1;
                        end
                    endcase
                    state <= DONE;
                end
                DONE: begin
                    ack_tgl <= ~ack_tgl;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A request arriving mid-command is dropped without an ack.
            if (req_edge && (state != IDLE)) overrun_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_debug_cmd_scheduler.sv
// Directed bench for jtag_debug_cmd_scheduler: a default instance for decode/latency
// checks and a short-timeout instance for the grant timeout path.
module tb_jtag_debug_cmd_scheduler;

    localparam int S_OCI_A = 10, S_OCI_B = 9, S_TR_A = 8, S_TR_B = 7;
    localparam int S_BRK_A = 6, S_BRK_B = 5, S_BRK_C = 4, S_TCTRL = 3;
    localparam int S_NO_OCI = 2, S_NO_TR = 1, S_NO_BRK = 0;
    localparam int TO2 = 4;

    typedef struct {
        logic [10:0] strobes;
        logic [37:0] jdo;
        int          str_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_tgl, req_tgl2;
    logic [1:0]  ir;
    logic [37:0] sr_in;
    logic        avs_busy, err_clr;

    logic        ack_tgl, busy, overrun_err, timeout_err;
    logic [37:0] jdo;
    logic [10:0] strobes;
    logic        ack_tgl2, busy2, overrun_err2, timeout_err2;
    logic [37:0] jdo2;
    logic [10:0] strobes2;

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_ack = 1'b0;
    logic exp_ack2 = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    jtag_debug_cmd_scheduler u_dut (
        .clk(clk), .reset_n(reset_n), .req_tgl(req_tgl), .ir_in(ir), .sr(sr_in),
        .avs_busy(avs_busy), .err_clr(err_clr), .ack_tgl(ack_tgl), .jdo(jdo),
        .take_action_ocimem_a(strobes[S_OCI_A]), .take_action_ocimem_b(strobes[S_OCI_B]),
        .take_action_tracemem_a(strobes[S_TR_A]), .take_action_tracemem_b(strobes[S_TR_B]),
        .take_action_break_a(strobes[S_BRK_A]), .take_action_break_b(strobes[S_BRK_B]),
        .take_action_break_c(strobes[S_BRK_C]), .take_action_tracectrl(strobes[S_TCTRL]),
        .take_no_action_ocimem_a(strobes[S_NO_OCI]), .take_no_action_tracemem_a(strobes[S_NO_TR]),
        .take_no_action_break_a(strobes[S_NO_BRK]),
        .busy(busy), .overrun_err(overrun_err), .timeout_err(timeout_err)
    );

    jtag_debug_cmd_scheduler #(.GRANT_TIMEOUT(TO2)) u_dut_to (
        .clk(clk), .reset_n(reset_n), .req_tgl(req_tgl2), .ir_in(ir), .sr(sr_in),
        .avs_busy(avs_busy), .err_clr(err_clr), .ack_tgl(ack_tgl2), .jdo(jdo2),
        .take_action_ocimem_a(strobes2[S_OCI_A]), .take_action_ocimem_b(strobes2[S_OCI_B]),
        .take_action_tracemem_a(strobes2[S_TR_A]), .take_action_tracemem_b(strobes2[S_TR_B]),
        .take_action_break_a(strobes2[S_BRK_A]), .take_action_break_b(strobes2[S_BRK_B]),
        .take_action_break_c(strobes2[S_BRK_C]), .take_action_tracectrl(strobes2[S_TCTRL]),
        .take_no_action_ocimem_a(strobes2[S_NO_OCI]), .take_no_action_tracemem_a(strobes2[S_NO_TR]),
        .take_no_action_break_a(strobes2[S_NO_BRK]),
        .busy(busy2), .overrun_err(overrun_err2), .timeout_err(timeout_err2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] decode(input logic [1:0] c_ir, input logic [37:0] s);
        logic [10:0] v;
        v = '0;
        case (c_ir)
            2'b00: begin
                if (s[34])      v[S_OCI_B]  = 1'b1;
                else if (s[35]) v[S_OCI_A]  = 1'b1;
                else            v[S_NO_OCI] = 1'b1;
            end
            2'b01: begin
                if (s[37])      v[S_TR_B]  = 1'b1;
                else if (s[36]) v[S_TR_A]  = 1'b1;
                else            v[S_NO_TR] = 1'b1;
            end
            2'b10: begin
                case (s[37:36])
                    2'b01:   v[S_BRK_A]  = 1'b1;
                    2'b10:   v[S_BRK_B]  = 1'b1;
                    2'b11:   v[S_BRK_C]  = 1'b1;
                    default: v[S_NO_BRK] = 1'b1;
                endcase
            end
            default: if (s[15]) v[S_TCTRL] = 1'b1;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command on the default instance; avs_busy is held high for busy_n cycles
    // starting with the first cycle the FSM samples it (CAPTURE).
    task automatic run_cmd(input logic [1:0] c_ir, input logic [37:0] s, input int busy_n);
        exp_t        e;
        logic [10:0] seen;
        int          n_str, str_k, ack_k, multi;
        sr_in    = s;
        ir       = c_ir;
        avs_busy = (busy_n > 0);
        e.strobes = decode(c_ir, s);
        e.jdo     = s;
        e.str_lat = 5 + busy_n;
        sb.push_back(e);
        req_tgl = ~req_tgl;
        seen = '0; n_str = 0; str_k = 0; ack_k = 0; multi = 0;
        for (int k = 1; k <= 80 && ack_k == 0; k++) begin
            tick();
            avs_busy = ((k + 1) <= (3 + busy_n));
            if (strobes != '0) begin
                seen |= strobes;
                n_str++;
                str_k = k;
                if ($countones(strobes) > 1) multi = 1;
            end
            if (ack_tgl !== exp_ack) ack_k = k;
        end
        exp_ack = ~exp_ack;
        e = sb.pop_front();
        check("strobe_sel", 64'(seen), 64'(e.strobes));
        check("strobe_cnt", 64'(n_str), (e.strobes != '0) ? 64'd1 : 64'd0);
        check("strobe_onehot", 64'(multi), 64'd0);
        if (e.strobes != '0) check("strobe_lat", 64'(str_k), 64'(e.str_lat));
        check("ack_lat", 64'(ack_k), 64'(e.str_lat + 1));
        check("ack_val", 64'(ack_tgl), 64'(exp_ack));
        check("jdo", 64'(jdo), 64'(e.jdo));
        check("busy_end", 64'(busy), 64'd0);
    endtask

    logic [6:0] tbl [13] = '{
        7'b00_0001_0, 7'b00_0011_0, 7'b00_0010_0, 7'b00_0000_1,
        7'b01_1100_0, 7'b01_0100_0, 7'b01_0011_0,
        7'b10_0100_0, 7'b10_1000_0, 7'b10_1100_0, 7'b10_0011_0,
        7'b11_0000_1, 7'b11_1111_0
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] s;
        logic [10:0] seen;
        int          n_str, n_ack, ack_k;
        logic        prev_ack;

        reset_n = 1'b0; req_tgl = 1'b0; req_tgl2 = 1'b0; ir = 2'b11;
        sr_in = '1; avs_busy = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("rst_strobes", 64'(strobes), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack_tgl), 64'd0);
        check("rst_errs", 64'({overrun_err, timeout_err}), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Basic: ir=00, sr[35]=1, sr[34]=0 -> ocimem_a at cycle 5
        s = {6'($urandom), $urandom()};
        s[35] = 1'b1; s[34] = 1'b0;
        run_cmd(2'b00, s, 0);
        repeat (2) tick();

        for (int i = 0; i < 13; i++) begin
            logic [6:0] t;
            t = tbl[i];
            s = {6'($urandom), $urandom()};
            s[37:34] = t[4:1];
            s[15]    = t[0];
            run_cmd(t[6:5], s, 0);
            repeat (2) tick();
        end

        // Grant wait: slave busy for 10 cycles from CAPTURE
        s = {6'($urandom), $urandom()};
        s[37:36] = 2'b10;
        run_cmd(2'b10, s, 10);
        check("no_timeout", 64'(timeout_err), 64'd0);
        repeat (2) tick();

        // Timeout on the short-timeout instance
        check("to_err_pre", 64'(timeout_err2), 64'd0);
        sr_in = '1; ir = 2'b00; avs_busy = 1'b1;
        req_tgl2 = ~req_tgl2;
        seen = '0; ack_k = 0;
        for (int k = 1; k <= 40 && ack_k == 0; k++) begin
            tick();
            seen |= strobes2;
            if (ack_tgl2 !== exp_ack2) ack_k = k;
        end
        exp_ack2 = ~exp_ack2;
        check("to_strobes", 64'(seen), 64'd0);
        check("to_ack_lat", 64'(ack_k), 64'(5 + TO2));
        check("to_ack_val", 64'(ack_tgl2), 64'(exp_ack2));
        check("to_err", 64'(timeout_err2), 64'd1);
        avs_busy = 1'b0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("to_err_clr", 64'(timeout_err2), 64'd0);
        repeat (2) tick();

        // Overrun: second edge two cycles after the first
        check("ovr_pre", 64'(overrun_err), 64'd0);
        s = {6'($urandom), $urandom()};
        s[34] = 1'b1;
        sr_in = s; ir = 2'b00;
        req_tgl = ~req_tgl;
        seen = '0; n_str = 0; n_ack = 0; prev_ack = ack_tgl;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) req_tgl = ~req_tgl;
            if (strobes != '0) begin seen |= strobes; n_str++; end
            if (ack_tgl !== prev_ack) n_ack++;
            prev_ack = ack_tgl;
        end
        exp_ack = ~exp_ack;
        check("ovr_strobe", 64'(seen), 64'(decode(2'b00, s)));
        check("ovr_strobe_cnt", 64'(n_str), 64'd1);
        check("ovr_ack_cnt", 64'(n_ack), 64'd1);
        check("ovr_ack_val", 64'(ack_tgl), 64'(exp_ack));
        check("ovr_err", 64'(overrun_err), 64'd1);
        check("ovr_busy", 64'(busy), 64'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("ovr_err_clr", 64'(overrun_err), 64'd0);
        repeat (2) tick();

        // Reset while waiting for grant
        sr_in = '1; ir = 2'b10; avs_busy = 1'b1;
        req_tgl = ~req_tgl;
        seen = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            seen |= strobes;
        end
        check("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0; req_tgl = 1'b0; req_tgl2 = 1'b0;
        exp_ack = 1'b0; exp_ack2 = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ack", 64'(ack_tgl), 64'd0);
        repeat (2) begin tick(); seen |= strobes; end
        check("mid_rst_strobes", 64'(seen), 64'd0);
        avs_busy = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 64'(busy), 64'd0);

        s = {6'($urandom), $urandom()};
        s[37:36] = 2'b10;
        run_cmd(2'b10, s, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
